// File: rtl/demux1x4_pipe.sv
// Pipelined 1:4 stream demux: in_sel[1] picks a stage-1 slot, then the stored in_sel[0] picks a stage-2 lane.
// Latency: 2 cycles from acceptance to out_valid. Sustains 1 word/cycle while the targeted lanes are ready.
// Backpressure: in_ready is combinational from out_ready through both stages. There is head-of-line blocking per half.
// Optional per-lane transfer counters on lane_cnt when DEMUX1X4_PIPE_STATS_EN is defined.
module demux1x4_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
`ifdef DEMUX1X4_PIPE_STATS_EN
  output logic [31:0]          lane_cnt,
`endif
  output logic [4*WIDTH-1:0]   out_data
);

  // Index 0 is slot L (lanes 0/1), index 1 is slot H (lanes 2/3).
  logic [1:0]            slot_vld_q, slot_vld_d;
  logic [1:0]            slot_sel_q, slot_sel_d;
  logic [1:0][WIDTH-1:0] slot_dat_q, slot_dat_d;
  logic [3:0]            lane_vld_q, lane_vld_d;
  logic [3:0][WIDTH-1:0] lane_dat_q, lane_dat_d;

  logic [3:0] lane_free;
  logic [3:0] lane_load;
  logic [1:0] slot_drain;
  logic [1:0] slot_free;
  logic [1:0] lane_idx;
  logic       accept;

  always_comb begin
    lane_free  = ~lane_vld_q | out_ready;
    lane_load  = '0;
    slot_drain = '0;
    slot_free  = '0;
    lane_idx   = '0;
    for (int h = 0; h < 2; h++) begin
      lane_idx            = {h[0], slot_sel_q[h]};
      slot_drain[h]       = slot_vld_q[h] && lane_free[lane_idx];
      slot_free[h]        = !slot_vld_q[h] || slot_drain[h];
      lane_load[lane_idx] = slot_drain[h];
    end
    in_ready = rst_n && slot_free[in_sel[1]];
    accept   = in_valid && in_ready;
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_sel_d = slot_sel_q;
    slot_dat_d = slot_dat_q;
    lane_vld_d = lane_vld_q;
    lane_dat_d = lane_dat_q;
    for (int h = 0; h < 2; h++) begin
      if (accept && (in_sel[1] == h[0])) begin
        slot_vld_d[h] = 1'b1;
        slot_sel_d[h] = in_sel[0];
        slot_dat_d[h] = in_data;
      end else if (slot_drain[h]) begin
        slot_vld_d[h] = 1'b0;
      end
    end
    // A refill wins over a drain, so a lane can stream without bubbles.
    for (int k = 0; k < 4; k++) begin
      if (lane_load[k]) begin
        lane_vld_d[k] = 1'b1;
        lane_dat_d[k] = slot_dat_q[k[1]];
      end else if (out_ready[k]) begin
        lane_vld_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      slot_sel_q <= '0;
      slot_dat_q <= '0;
      lane_vld_q <= '0;
      lane_dat_q <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_sel_q <= slot_sel_d;
      slot_dat_q <= slot_dat_d;
      lane_vld_q <= lane_vld_d;
      lane_dat_q <= lane_dat_d;
    end
  end

  assign out_valid = lane_vld_q;
  assign out_data  = lane_dat_q;

`ifdef DEMUX1X4_PIPE_STATS_EN
  logic [3:0][7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k] + 8'(lane_vld_q[k] && out_ready[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lane_cnt = cnt_q;
`endif

endmodule
